// File: rtl/digit_pkg.sv
// Shared types and constants for the SPI image loader front end.
package digit_pkg;

    localparam int NUM_PIXELS  = 144;
    localparam int PIXEL_W     = 4;
    localparam int SYNC_STAGES = 2;

    localparam logic [7:0] CMD_START = 8'h00;
    localparam logic [7:0] CMD_RUN   = 8'hFF;
    localparam logic [7:0] RESULT_NONE = 8'hFF;

    // Pointer value of the final pixel pair; reaching it completes the image.
    localparam logic [7:0] LAST_PTR = 8'(NUM_PIXELS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/spi_slave_phy.sv
// SPI slave physical layer: input synchronisers, SCK/SS edge detection,
// LSB-first receive shifter with byte strobe and LSB-first transmit shifter.
module spi_slave_phy
    import digit_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    input  logic [7:0] tx_data,
    output logic       miso,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic                   ss_prev_r;
    logic [2:0]             bitcnt_r;
    logic [7:0]             rx_r;
    logic [7:0]             tx_r;
    logic [7:0]             tx_nxt_s;
    logic                   byte_done_r;
    logic                   miso_r;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise_s, sck_fall_s, ss_fall_s, ss_rise_s;

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign ss_s       = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign ss_fall_s  = ~ss_s & ss_prev_r;
    assign ss_rise_s  = ss_s & ~ss_prev_r;

    // Synchronise async SPI pins; SS resets to its idle level so no false frame edge appears.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_sync_r  <= '0;
            ss_sync_r   <= '1;
            mosi_sync_r <= '0;
            sck_prev_r  <= 1'b0;
            ss_prev_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sck_prev_r  <= sck_s;
            ss_prev_r   <= ss_s;
        end
    end

    // Receive shifter; a frame closed early drops its partial byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_r        <= 8'h00;
            bitcnt_r    <= 3'd0;
            byte_done_r <= 1'b0;
        end else if (ss_rise_s) begin
            bitcnt_r    <= 3'd0;
            byte_done_r <= 1'b0;
        end else if (sck_rise_s && !ss_s) begin
            rx_r        <= {mosi_s, rx_r[7:1]};
            bitcnt_r    <= bitcnt_r + 3'd1;
            byte_done_r <= (bitcnt_r == 3'd7);
        end else begin
            byte_done_r <= 1'b0;
        end
    end

    // Next transmit shifter contents: load on frame start, shift on SCK fall.
    always_comb begin
        tx_nxt_s = tx_r;
        if (ss_fall_s) begin
            tx_nxt_s = tx_data;
        end else if (sck_fall_s && !ss_s) begin
            tx_nxt_s = {1'b0, tx_r[7:1]};
        end else begin
            tx_nxt_s = tx_r;
        end
    end

    // Transmit shifter and registered MISO, forced low outside a frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_r   <= 8'h00;
            miso_r <= 1'b0;
        end else begin
            tx_r   <= tx_nxt_s;
            miso_r <= ss_s ? 1'b0 : tx_nxt_s[0];
        end
    end

    assign miso      = miso_r;
    assign byte_done = byte_done_r;
    assign rx_byte   = rx_r;

endmodule

// File: rtl/spi_image_loader.sv
// SPI image loader: command FSM, pixel pointer, two-nibble write sequencer
// and result register in front of the digit recognition core.
module spi_image_loader
    import digit_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               SCK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               pix_we,
    output logic [7:0]         pix_addr,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               start,
    input  logic               result_valid,
    input  logic [7:0]         result_digit,
    output logic               busy
);

    loader_state_t      state_r, state_nxt_s;
    logic [7:0]         ptr_r, ptr_nxt_s;
    logic [7:0]         byte_r, byte_nxt_s;
    logic               hi_pend_r, hi_pend_nxt_s;
    logic [7:0]         result_r, result_nxt_s;
    logic               we_r, we_nxt_s;
    logic [7:0]         addr_r, addr_nxt_s;
    logic [PIXEL_W-1:0] data_r, data_nxt_s;
    logic               start_r, start_nxt_s;
    logic               busy_r;
    logic               byte_done_s;
    logic [7:0]         rx_byte_s;

    spi_slave_phy u_phy (
        .clk       (clk),
        .n_rst     (n_rst),
        .sck       (SCK),
        .ss        (SS),
        .mosi      (MOSI),
        .tx_data   (result_r),
        .miso      (MISO),
        .byte_done (byte_done_s),
        .rx_byte   (rx_byte_s)
    );

    // Next-state and next-output logic; the high nibble is written the cycle after the low one.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        byte_nxt_s    = byte_r;
        hi_pend_nxt_s = 1'b0;
        result_nxt_s  = result_r;
        we_nxt_s      = 1'b0;
        addr_nxt_s    = addr_r;
        data_nxt_s    = data_r;
        start_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (byte_done_s && (rx_byte_s == CMD_START)) begin
                    state_nxt_s = LOAD;
                    ptr_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (hi_pend_r) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = ptr_r + 8'd1;
                    data_nxt_s  = byte_r[2*PIXEL_W-1:PIXEL_W];
                    ptr_nxt_s   = ptr_r + 8'd2;
                    state_nxt_s = (ptr_r == LAST_PTR) ? ARM : LOAD;
                end else if (byte_done_s) begin
                    we_nxt_s      = 1'b1;
                    addr_nxt_s    = ptr_r;
                    data_nxt_s    = rx_byte_s[PIXEL_W-1:0];
                    byte_nxt_s    = rx_byte_s;
                    hi_pend_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            ARM: begin
                if (byte_done_s && (rx_byte_s == CMD_RUN)) begin
                    start_nxt_s  = 1'b1;
                    result_nxt_s = RESULT_NONE;
                    state_nxt_s  = RUN;
                end else if (byte_done_s && (rx_byte_s == CMD_START)) begin
                    state_nxt_s = LOAD;
                    ptr_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            RUN: begin
                if (result_valid) begin
                    result_nxt_s = result_digit;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = 8'd0;
            end
        endcase
    end

    // State, sequencer and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= IDLE;
            ptr_r     <= 8'd0;
            byte_r    <= 8'h00;
            hi_pend_r <= 1'b0;
            result_r  <= RESULT_NONE;
            we_r      <= 1'b0;
            addr_r    <= 8'd0;
            data_r    <= '0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            byte_r    <= byte_nxt_s;
            hi_pend_r <= hi_pend_nxt_s;
            result_r  <= result_nxt_s;
            we_r      <= we_nxt_s;
            addr_r    <= addr_nxt_s;
            data_r    <= data_nxt_s;
            start_r   <= start_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    assign pix_we   = we_r;
    assign pix_addr = addr_r;
    assign pix_data = data_r;
    assign start    = start_r;
    assign busy     = busy_r;

endmodule
